// File: rtl/matrix_scan_decoder_if.sv
// Bus bundle for the keyboard/LED matrix scan decoder: scanned row/column
// inputs, display-buffer read port, frame status and the error flag.
interface matrix_scan_decoder_if;
    logic [7:0]  row;
    logic [15:0] col;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
    logic        err_row;
    logic        err_clr;

    modport master (
        output row, col, rd_addr, err_clr,
        input  rd_data, frame_valid, frame_cnt, err_row
    );

    modport slave (
        input  row, col, rd_addr, err_clr,
        output rd_data, frame_valid, frame_cnt, err_row
    );
endinterface

// File: rtl/matrix_scan_decoder.sv
// Matrix scan decoder: synchronizes an externally scanned active-low row
// select and its column data, samples each row once it has been stable for
// SETTLE cycles, collects a full frame of 8 rows in a shadow buffer and
// commits it atomically to a readable display buffer.
module matrix_scan_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_scan_decoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLING = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [7:0]  r_rowMeta;
    logic [7:0]  r_rowSync;
    logic [7:0]  r_rowPrev;
    logic [15:0] r_colMeta;
    logic [15:0] r_colSync;

    logic [1:0]  r_state;
    logic [1:0]  w_stateNext;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cntNext;

    logic [7:0]  r_seen;
    logic [15:0] r_shadow  [8];
    logic [15:0] r_display [8];
    logic [15:0] r_rdData;
    logic [7:0]  r_frameCnt;
    logic        r_errRow;

    logic [3:0]  w_zeroCount;
    logic [2:0]  w_rowIndex;
    logic        w_rowChanged;
    logic        w_rowLegal;
    logic        w_rowIllegal;
    logic        w_capture;
    logic        w_commit;
    logic [7:0]  w_captureMask;

    // Two-flop synchronizers for the asynchronous row/col pins, plus a copy of
    // the last synchronized row used to detect code changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rowMeta <= 8'hFF;
            r_rowSync <= 8'hFF;
            r_rowPrev <= 8'hFF;
            r_colMeta <= 16'h0000;
            r_colSync <= 16'h0000;
        end else begin
            r_rowMeta <= bus.row;
            r_rowSync <= r_rowMeta;
            r_rowPrev <= r_rowSync;
            r_colMeta <= bus.col;
            r_colSync <= r_colMeta;
        end
    end

    // Count the zero bits of the synchronized row and locate the selected line.
    always_comb begin
        w_zeroCount = 4'd0;
        w_rowIndex  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_rowSync[i]) begin
                w_zeroCount = w_zeroCount + 4'd1;
                w_rowIndex  = 3'(i);
            end
        end
    end

    assign w_rowChanged  = (r_rowSync != r_rowPrev);
    assign w_rowLegal    = (w_zeroCount == 4'd1);
    assign w_rowIllegal  = (w_zeroCount >= 4'd2);
    assign w_commit      = (r_seen == 8'hFF);
    assign w_captureMask = w_capture ? (8'd1 << w_rowIndex) : 8'd0;

    // Row FSM: a fresh legal code counts as stability cycle 0, and the line is
    // sampled once when the code has been unchanged for SETTLE cycles.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_capture   = 1'b0;
        if (!w_rowLegal) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = 8'd0;
        end else if (w_rowChanged || r_state == ST_IDLE) begin
            if (SETTLE_LAST == 8'd0) begin
                w_capture   = 1'b1;
                w_stateNext = ST_CAPTURED;
                w_cntNext   = 8'd0;
            end else begin
                w_stateNext = ST_SETTLING;
                w_cntNext   = 8'd1;
            end
        end else if (r_state == ST_SETTLING) begin
            if (r_cnt == SETTLE_LAST) begin
                w_capture   = 1'b1;
                w_stateNext = ST_CAPTURED;
                w_cntNext   = 8'd0;
            end else begin
                w_cntNext   = r_cnt + 8'd1;
            end
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Shadow buffer collects captured lines; seen is cleared by a commit but a
    // capture in the same cycle already counts toward the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 16'h0000;
            end
        end else begin
            r_seen <= (w_commit ? 8'h00 : r_seen) | w_captureMask;
            if (w_capture) begin
                r_shadow[w_rowIndex] <= r_colSync;
            end
        end
    end

    // Whole-frame copy into the display buffer and frame counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameCnt <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_display[i] <= 16'h0000;
            end
        end else if (w_commit) begin
            r_frameCnt <= r_frameCnt + 8'd1;
            for (int i = 0; i < 8; i++) begin
                r_display[i] <= r_shadow[i];
            end
        end
    end

    // Registered read port; a read coinciding with a commit sees the old frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= 16'h0000;
        end else begin
            r_rdData <= r_display[bus.rd_addr];
        end
    end

    // Sticky illegal-row flag; a present illegal code outranks a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_errRow <= 1'b0;
        end else if (w_rowIllegal) begin
            r_errRow <= 1'b1;
        end else if (bus.err_clr) begin
            r_errRow <= 1'b0;
        end
    end

    assign bus.rd_data     = r_rdData;
    assign bus.frame_valid = w_commit;
    assign bus.frame_cnt   = r_frameCnt;
    assign bus.err_row     = r_errRow;

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Self-checking bench for matrix_scan_decoder: directed scenarios plus a
// randomized row/col stream compared against a segment-level frame model.
module tb_matrix_scan_decoder;

    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    matrix_scan_decoder_if bus ();

    matrix_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int pulseCount = 0;

    logic [15:0] mShadow  [8];
    logic [15:0] mDisplay [8];
    logic [7:0]  mSeen;
    logic [7:0]  mFrames;
    logic [7:0]  mPrevCode;
    logic        mErr;
    logic        mRunCaptured;
    int          mRunLen;
    int          mPulses;

    // Count frame_valid pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) pulseCount <= pulseCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mShadow[i]  = 16'h0000;
            mDisplay[i] = 16'h0000;
        end
        mSeen        = 8'h00;
        mFrames      = 8'd0;
        mPrevCode    = 8'hFF;
        mErr         = 1'b0;
        mRunCaptured = 1'b0;
        mRunLen      = 0;
        mPulses      = 0;
    endtask

    // A code held for a run of at least SETTLE cycles is captured once, using
    // the column value of the segment in which the run reaches SETTLE.
    task automatic modelSegment(input logic [7:0] code, input logic [15:0] c, input int len);
        int zeros;
        int k;
        if (code == mPrevCode) begin
            mRunLen = mRunLen + len;
        end else begin
            mPrevCode    = code;
            mRunLen      = len;
            mRunCaptured = 1'b0;
        end
        zeros = $countones(~code);
        if (zeros >= 2) begin
            mErr = 1'b1;
        end else if (zeros == 1 && !mRunCaptured && mRunLen >= SETTLE) begin
            k = 0;
            for (int i = 0; i < 8; i++) if (!code[i]) k = i;
            mShadow[k]   = c;
            mSeen[k]     = 1'b1;
            mRunCaptured = 1'b1;
            if (mSeen == 8'hFF) begin
                for (int i = 0; i < 8; i++) mDisplay[i] = mShadow[i];
                mSeen   = 8'h00;
                mFrames = mFrames + 8'd1;
                mPulses = mPulses + 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic [15:0] c, input int len);
        bus.row = code;
        bus.col = c;
        repeat (len) @(negedge clk);
        modelSegment(code, c, len);
    endtask

    task automatic doReset();
        rst         = 1'b1;
        bus.row     = 8'hFF;
        bus.col     = 16'h0000;
        bus.err_clr = 1'b0;
        bus.rd_addr = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic readCheck(input string tag, input logic [2:0] addr, input logic [15:0] expected);
        bus.rd_addr = addr;
        @(negedge clk);
        checkOutput(tag, bus.rd_data, expected);
    endtask

    task automatic scanSpecFrame(input int hold);
        logic [15:0] c;
        for (int k = 7; k >= 0; k--) begin
            c = 16'h0101 * 16'(k + 1);
            applyStimulus(~(8'd1 << k), c, hold);
        end
    endtask

    initial begin
        int          p0;
        int          found;
        logic [7:0]  code;
        logic [15:0] c;
        int          a;
        int          b;
        int          len;
        int          sel;

        rst         = 1'b1;
        bus.row     = 8'hFF;
        bus.col     = 16'h0000;
        bus.err_clr = 1'b0;
        bus.rd_addr = 3'd0;
        repeat (2) @(negedge clk);
        doReset();

        $display("[TB] reset state");
        checkOutput("rstRdData", bus.rd_data, 16'h0000);
        checkOutput("rstFrameValid", {15'h0, bus.frame_valid}, 16'h0000);
        checkOutput("rstFrameCnt", {8'h00, bus.frame_cnt}, 16'h0000);
        checkOutput("rstErrRow", {15'h0, bus.err_row}, 16'h0000);

        $display("[TB] full frame scan");
        p0 = pulseCount;
        scanSpecFrame(10);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("frameCnt1", {8'h00, bus.frame_cnt}, 16'h0001);
        checkOutput("framePulses1", 16'(pulseCount - p0), 16'd1);
        readCheck("line3", 3'd3, 16'h0404);
        readCheck("line0", 3'd0, 16'h0101);
        readCheck("line7", 3'd7, 16'h0808);

        $display("[TB] read during commit");
        for (int k = 7; k >= 1; k--) applyStimulus(~(8'd1 << k), 16'hA000 | 16'(k), 10);
        bus.rd_addr = 3'd1;
        bus.row     = 8'hFE;
        bus.col     = 16'hA000;
        found       = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) found = 1;
        end
        checkOutput("commitSeen", 16'(found), 16'd1);
        bus.rd_addr = 3'd0;
        @(negedge clk);
        checkOutput("readOnCommit", bus.rd_data, 16'h0101);
        @(negedge clk);
        checkOutput("readAfterCommit", bus.rd_data, 16'hA000);
        modelSegment(8'hFE, 16'hA000, SETTLE);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("frameCnt2", {8'h00, bus.frame_cnt}, 16'h0002);

        $display("[TB] short hold");
        doReset();
        p0 = pulseCount;
        applyStimulus(8'hFB, 16'h1234, SETTLE - 1);
        applyStimulus(8'hFF, 16'h0000, 8);
        checkOutput("shortHoldSeen", {8'h00, dut.r_seen}, 16'h0000);
        checkOutput("shortHoldPulses", 16'(pulseCount - p0), 16'd0);
        for (int k = 7; k >= 0; k--) if (k != 2) applyStimulus(~(8'd1 << k), 16'(k), 6);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("sevenRowsNoFrame", {8'h00, bus.frame_cnt}, 16'h0000);
        applyStimulus(8'hFB, 16'h5A5A, SETTLE);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("exactHoldFrame", {8'h00, bus.frame_cnt}, 16'h0001);
        readCheck("exactHoldLine2", 3'd2, 16'h5A5A);

        $display("[TB] illegal row and err_clr");
        doReset();
        applyStimulus(8'hF3, 16'hFFFF, 10);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("illegalErr", {15'h0, bus.err_row}, 16'h0001);
        checkOutput("illegalSeen", {8'h00, dut.r_seen}, 16'h0000);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
        checkOutput("errCleared", {15'h0, bus.err_row}, 16'h0000);
        bus.row = 8'h00;
        repeat (2) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checkOutput("errClrLoses", {15'h0, bus.err_row}, 16'h0001);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("errSticky", {15'h0, bus.err_row}, 16'h0001);

        $display("[TB] frame counter wrap");
        doReset();
        p0 = pulseCount;
        for (int f = 0; f < 255; f++) begin
            for (int k = 7; k >= 0; k--) applyStimulus(~(8'd1 << k), 16'($urandom), SETTLE + 1);
        end
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("frameCnt255", {8'h00, bus.frame_cnt}, 16'h00FF);
        for (int k = 7; k >= 0; k--) applyStimulus(~(8'd1 << k), 16'($urandom), SETTLE + 1);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("frameCntWrap", {8'h00, bus.frame_cnt}, 16'h0000);
        checkOutput("wrapPulses", 16'(pulseCount - p0), 16'd256);
        readCheck("wrapLine5", 3'd5, mDisplay[5]);

        $display("[TB] reset mid-frame");
        doReset();
        p0 = pulseCount;
        for (int k = 7; k >= 3; k--) applyStimulus(~(8'd1 << k), 16'hC000 | 16'(k), 10);
        applyStimulus(8'hFF, 16'h0000, 4);
        doReset();
        for (int k = 2; k >= 0; k--) applyStimulus(~(8'd1 << k), 16'hD000 | 16'(k), 10);
        applyStimulus(8'hFF, 16'h0000, 6);
        checkOutput("midResetPulses", 16'(pulseCount - p0), 16'd0);
        checkOutput("midResetFrameCnt", {8'h00, bus.frame_cnt}, 16'h0000);
        for (int k = 0; k < 8; k++) readCheck($sformatf("midResetLine%0d", k), 3'(k), 16'h0000);

        $display("[TB] randomized stream");
        doReset();
        p0 = pulseCount;
        for (int s = 1; s <= 400; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                code = ~(8'd1 << $urandom_range(0, 7));
            end else if (sel < 8) begin
                code = 8'hFF;
            end else begin
                code = 8'($urandom);
                a = $urandom_range(0, 7);
                b = (a + 1 + $urandom_range(0, 6)) % 8;
                code[a] = 1'b0;
                code[b] = 1'b0;
            end
            len = $urandom_range(1, 12);
            c   = 16'($urandom);
            applyStimulus(code, c, len);
            if (s % 50 == 0) begin
                applyStimulus(8'hFF, 16'h0000, 6);
                checkOutput($sformatf("rndFrameCnt%0d", s), {8'h00, bus.frame_cnt}, {8'h00, mFrames});
                checkOutput($sformatf("rndErr%0d", s), {15'h0, bus.err_row}, {15'h0, mErr});
                checkOutput($sformatf("rndPulses%0d", s), 16'(pulseCount - p0), 16'(mPulses));
            end
        end
        for (int k = 0; k < 8; k++) readCheck($sformatf("rndLine%0d", k), 3'(k), mDisplay[k]);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
